// File: rtl/wb_unit.sv
// Write-back stage: load-data extraction, write-back mux, register-file write port,
// halt/resume state machine, retired-instruction counter and a delayed write record
// for the decode-stage bypass.
module wb_unit #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      read_data_in,
  input  logic [31:0]      sig_in,
  input  logic [31:0]      AluOut_in,
  input  logic [31:0]      IR_in,
  input  logic [31:0]      PC_in,
  input  logic [4:0]       RDdst_in,
  input  logic             halt_in,
  input  logic             resume,
  output logic             reg_we,
  output logic [4:0]       reg_waddr,
  output logic [31:0]      reg_wdata,
  output logic             last_we,
  output logic [4:0]       last_waddr,
  output logic [31:0]      last_wdata,
  output logic             halted,
  output logic [CNT_W-1:0] retired,
  output logic             misalign
);

  localparam logic [5:0] OpLb  = 6'h20;
  localparam logic [5:0] OpLh  = 6'h21;
  localparam logic [5:0] OpLw  = 6'h23;
  localparam logic [5:0] OpLbu = 6'h24;
  localparam logic [5:0] OpLhu = 6'h25;

  typedef enum logic {StRun, StHalted} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             misalign_q, misalign_d;
  logic             last_we_q;
  logic [4:0]       last_waddr_q;
  logic [31:0]      last_wdata_q;

  logic        reg_write, mem_to_reg, link, run;
  logic [5:0]  opcode;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;
  logic        unused_sig;

  assign reg_write  = sig_in[0];
  assign mem_to_reg = sig_in[1];
  assign link       = sig_in[2];
  assign unused_sig = ^sig_in[31:3];
  assign opcode     = IR_in[31:26];
  assign run        = (state_q == StRun);

  // Little-endian lane selection and sign/zero extension of the loaded datum
  always_comb begin
    lane_byte = read_data_in[7:0];
    case (AluOut_in[1:0])
      2'd0:    lane_byte = read_data_in[7:0];
      2'd1:    lane_byte = read_data_in[15:8];
      2'd2:    lane_byte = read_data_in[23:16];
      default: lane_byte = read_data_in[31:24];
    endcase
    lane_half = AluOut_in[1] ? read_data_in[31:16] : read_data_in[15:0];
    case (opcode)
      OpLb:    load_data = {{24{lane_byte[7]}}, lane_byte};
      OpLbu:   load_data = {24'h0, lane_byte};
      OpLh:    load_data = {{16{lane_half[15]}}, lane_half};
      OpLhu:   load_data = {16'h0, lane_half};
      default: load_data = read_data_in;
    endcase
  end

  // Write-port drive: link beats load beats ALU; $0 writes never reach the file
  always_comb begin
    reg_waddr = link ? 5'd31 : RDdst_in;
    if (link) begin
      reg_wdata = PC_in + 32'd4;
    end else if (mem_to_reg) begin
      reg_wdata = load_data;
    end else begin
      reg_wdata = AluOut_in;
    end
    reg_we = reg_write & run & (reg_waddr != 5'd0);
  end

  // Next-state for halt FSM, retire counter and sticky misalign flag
  always_comb begin
    state_d    = state_q;
    retired_d  = retired_q;
    misalign_d = misalign_q;
    unique case (state_q)
      StRun:    if (halt_in) state_d = StHalted;
      StHalted: if (resume)  state_d = StRun;
      default:  state_d = StRun;
    endcase
    if (run && (IR_in != 32'd0)) begin
      retired_d = retired_q + 1'b1;
    end
    if (run && mem_to_reg) begin
      if ((opcode == OpLw) && (AluOut_in[1:0] != 2'd0)) begin
        misalign_d = 1'b1;
      end
      if (((opcode == OpLh) || (opcode == OpLhu)) && AluOut_in[0]) begin
        misalign_d = 1'b1;
      end
    end
  end

  // State registers, including the one-cycle-delayed write record
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StRun;
      retired_q    <= '0;
      misalign_q   <= 1'b0;
      last_we_q    <= 1'b0;
      last_waddr_q <= 5'd0;
      last_wdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      retired_q    <= retired_d;
      misalign_q   <= misalign_d;
      last_we_q    <= reg_we;
      last_waddr_q <= reg_waddr;
      last_wdata_q <= reg_wdata;
    end
  end

  assign halted     = (state_q == StHalted);
  assign retired    = retired_q;
  assign misalign   = misalign_q;
  assign last_we    = last_we_q;
  assign last_waddr = last_waddr_q;
  assign last_wdata = last_wdata_q;

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit; a second 4-bit-counter instance checks counter wrap.
module tb_wb_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] read_data_in, sig_in, AluOut_in, IR_in, PC_in;
  logic [4:0]  RDdst_in;
  logic        halt_in, resume;

  logic        reg_we, last_we, halted, misalign;
  logic [4:0]  reg_waddr, last_waddr;
  logic [31:0] reg_wdata, last_wdata, retired;

  logic        reg_we4, last_we4, halted4, misalign4;
  logic [4:0]  reg_waddr4, last_waddr4;
  logic [31:0] reg_wdata4, last_wdata4;
  logic [3:0]  retired4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_unit #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .read_data_in(read_data_in), .sig_in(sig_in),
    .AluOut_in(AluOut_in), .IR_in(IR_in), .PC_in(PC_in), .RDdst_in(RDdst_in),
    .halt_in(halt_in), .resume(resume), .reg_we(reg_we), .reg_waddr(reg_waddr),
    .reg_wdata(reg_wdata), .last_we(last_we), .last_waddr(last_waddr),
    .last_wdata(last_wdata), .halted(halted), .retired(retired), .misalign(misalign)
  );

  wb_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .read_data_in(read_data_in), .sig_in(sig_in),
    .AluOut_in(AluOut_in), .IR_in(IR_in), .PC_in(PC_in), .RDdst_in(RDdst_in),
    .halt_in(halt_in), .resume(resume), .reg_we(reg_we4), .reg_waddr(reg_waddr4),
    .reg_wdata(reg_wdata4), .last_we(last_we4), .last_waddr(last_waddr4),
    .last_wdata(last_wdata4), .halted(halted4), .retired(retired4),
    .misalign(misalign4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] sig, input logic [31:0] ir, input logic [31:0] alu,
                       input logic [4:0] dst, input logic hlt, input logic res);
    sig_in    = sig;
    IR_in     = ir;
    AluOut_in = alu;
    RDdst_in  = dst;
    halt_in   = hlt;
    resume    = res;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b0;
    read_data_in = 32'h80FF7F01;
    PC_in        = 32'h00400010;
    drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    #2;
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    check("rst_last_we", {31'd0, last_we}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // ALU write
    drive(32'h1, 32'h01000000, 32'h1234, 5'd8, 1'b0, 1'b0);
    check("alu_we", {31'd0, reg_we}, 32'd1);
    check("alu_addr", {27'd0, reg_waddr}, 32'd8);
    check("alu_data", reg_wdata, 32'h1234);
    tick();
    check("alu_last_we", {31'd0, last_we}, 32'd1);
    check("alu_last_addr", {27'd0, last_waddr}, 32'd8);
    check("alu_last_data", last_wdata, 32'h1234);
    check("alu_retired", retired, 32'd1);

    // Loads from 0x80FF7F01
    drive(32'h3, 32'h80000000, 32'h3, 5'd9, 1'b0, 1'b0);
    check("lb_lane3", reg_wdata, 32'hFFFFFF80);
    tick();
    drive(32'h3, 32'h90000000, 32'h1, 5'd9, 1'b0, 1'b0);
    check("lbu_lane1", reg_wdata, 32'h0000007F);
    tick();
    drive(32'h3, 32'h84000000, 32'h2, 5'd9, 1'b0, 1'b0);
    check("lh_half1", reg_wdata, 32'hFFFF80FF);
    tick();
    drive(32'h3, 32'h94000000, 32'h0, 5'd9, 1'b0, 1'b0);
    check("lhu_half0", reg_wdata, 32'h00007F01);
    tick();
    drive(32'h3, 32'h8C000000, 32'h0, 5'd9, 1'b0, 1'b0);
    check("lw_word", reg_wdata, 32'h80FF7F01);
    check("lw_we", {31'd0, reg_we}, 32'd1);
    tick();
    check("loads_retired", retired, 32'd6);
    check("loads_no_misalign", {31'd0, misalign}, 32'd0);

    // Link and $0
    drive(32'h5, 32'h0C000000, 32'h0, 5'd5, 1'b0, 1'b0);
    check("jal_addr", {27'd0, reg_waddr}, 32'd31);
    check("jal_data", reg_wdata, 32'h00400014);
    check("jal_we", {31'd0, reg_we}, 32'd1);
    tick();
    drive(32'h1, 32'h01000000, 32'h77, 5'd0, 1'b0, 1'b0);
    check("r0_we", {31'd0, reg_we}, 32'd0);
    tick();
    check("r0_retired", retired, 32'd8);
    check("r0_last_we", {31'd0, last_we}, 32'd0);

    // Bubbles
    drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    check("bubble_retired", retired, 32'd8);

    // Halt with write, then frozen in HALTED
    drive(32'h1, 32'h0000000C, 32'hAA, 5'd10, 1'b1, 1'b0);
    check("halt_we", {31'd0, reg_we}, 32'd1);
    tick();
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_retired", retired, 32'd9);
    check("halt_last_addr", {27'd0, last_waddr}, 32'd10);
    drive(32'h1, 32'h01000000, 32'hBB, 5'd11, 1'b0, 1'b0);
    check("halted_we", {31'd0, reg_we}, 32'd0);
    tick();
    check("halted_retired", retired, 32'd9);
    check("halted_last_we", {31'd0, last_we}, 32'd0);
    // resume together with halt_in: halt_in ignored
    drive(32'h1, 32'h01000000, 32'hBB, 5'd11, 1'b1, 1'b1);
    check("resume_cycle_we", {31'd0, reg_we}, 32'd0);
    tick();
    check("resume_halted", {31'd0, halted}, 32'd0);
    check("resume_retired", retired, 32'd9);
    drive(32'h1, 32'h01000000, 32'h55, 5'd12, 1'b0, 1'b0);
    check("resumed_we", {31'd0, reg_we}, 32'd1);
    tick();
    check("resumed_retired", retired, 32'd10);
    drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
    tick();
    check("resume_in_run", {31'd0, halted}, 32'd0);

    // Misaligned LW still writes the whole word; flag sticks
    drive(32'h3, 32'h8C000000, 32'h2, 5'd13, 1'b0, 1'b0);
    check("mis_lw_data", reg_wdata, 32'h80FF7F01);
    check("mis_lw_we", {31'd0, reg_we}, 32'd1);
    tick();
    check("mis_set", {31'd0, misalign}, 32'd1);
    drive(32'h3, 32'h8C000000, 32'h0, 5'd13, 1'b0, 1'b0);
    tick();
    check("mis_sticky", {31'd0, misalign}, 32'd1);
    check("mis_retired", retired, 32'd12);

    // Four more retirements: 16 total, 4-bit counter wraps to 0
    drive(32'h0, 32'h01000000, 32'h0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    check("wrap_retired32", retired, 32'd16);
    check("wrap_retired4", {28'd0, retired4}, 32'd0);

    // Reset asserted mid-HALTED takes effect without a clock edge
    drive(32'h1, 32'h0000000C, 32'hCC, 5'd14, 1'b1, 1'b0);
    tick();
    check("pre_rst_halted", {31'd0, halted}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_halted", {31'd0, halted}, 32'd0);
    check("arst_retired", retired, 32'd0);
    check("arst_misalign", {31'd0, misalign}, 32'd0);
    check("arst_last_we", {31'd0, last_we}, 32'd0);
    check("arst_last_addr", {27'd0, last_waddr}, 32'd0);
    check("arst_last_data", last_wdata, 32'd0);
    check("arst_comb_we", {31'd0, reg_we}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_unit.md
# wb_unit

Write-back stage of the five-stage MIPS pipeline: consumes the MEM/WB pipeline register outputs each cycle. It performs load-data extraction, selects the write-back value and drives the register-file write port. It maintains a halt state machine, a retired-instruction counter and a one-cycle-delayed write record for the decode-stage bypass.

## Interface
Parameters:
- `CNT_W`, 32, width of retired-instruction counter

Ports:
- `clk`  in  1  pipeline clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `read_data_in`  in  32  raw word from data memory (MEM/WB)
- `sig_in`  in  32  control word; bit0 reg_write, bit1 mem_to_reg, bit2 link; other bits ignored
- `AluOut_in`  in  32  ALU result / effective address
- `IR_in`  in  32  instruction word; 0 = bubble
- `PC_in`  in  32  PC of instruction
- `RDdst_in`  in  5  destination register
- `halt_in`  in  1  instruction is the halting syscall
- `resume`  in  1  single-cycle pulse: leave HALTED
- `reg_we`  out  1  register-file write enable
- `reg_waddr`  out  5  write address
- `reg_wdata`  out  32  write data
- `last_we` / `last_waddr` / `last_wdata`  out  1/5/32  registered copy of the previous cycle's write
- `halted`  out  1  high in HALTED
- `retired`  out  CNT_W  retired-instruction count
- `misalign`  out  1  sticky misaligned-load flag

## Operation
- States: RUN, HALTED. Reset → RUN.
- RUN, `halt_in`=1: the instruction itself is processed normally. Its write is still allowed if `sig_in[0]`, and it is counted. Next state HALTED.
- HALTED: `reg_we` forced 0, counter frozen, `halt_in` ignored, `last_we` records 0. `resume`=1 → RUN next cycle. `resume` in RUN has no effect.
- Load extraction applies when `sig_in[1]`=1. Opcode = `IR_in[31:26]`. Lane = `AluOut_in[1:0]`, little-endian, so byte k = `read_data_in[8k+7:8k]`.
  - 0x20 LB: selected byte, sign-extended.
  - 0x24 LBU: selected byte, zero-extended.
  - 0x21 LH: half `AluOut_in[1]` (0 → bits 15:0, 1 → bits 31:16), sign-extended.
  - 0x25 LHU: same half selection, zero-extended.
  - 0x23 LW, or any other opcode: whole word.
- Write-data priority: link (`PC_in`+4, modulo 2^32) > mem_to_reg (extracted load) > `AluOut_in`.
- `reg_waddr` = 31 when link=1, else `RDdst_in`.
- `reg_we` = `sig_in[0]` & state==RUN & `reg_waddr`≠0. Writes to $0 are always suppressed.
- Retire: count +1 when state==RUN and `IR_in`≠0. Bubbles are not counted. The counter wraps 2^CNT_W−1 → 0.
- Misalign: set when state==RUN, mem_to_reg=1 and either LW/LH/LHU with `AluOut_in[1:0]`≠0 for LW or `AluOut_in[0]`=1 for halfword. The write still occurs with the lane data defined above. Cleared only by reset.

## Timing
- `reg_we`/`reg_waddr`/`reg_wdata` are combinational from the inputs and the current state. The register file commits at the next rising `clk`. Zero added latency.
- `last_*` are updated every rising edge with the current cycle's `reg_we`/`reg_waddr`/`reg_wdata`, so they are valid one cycle after the write.
- `halted` rises on the edge after the halt instruction is presented. It falls on the edge after `resume`.
- `resume` and `halt_in` asserted together in HALTED: the result is RUN, and that cycle's `halt_in` is ignored.
- Reset asserted at any time, including mid-HALTED: state RUN, `retired`=0, `misalign`=0, `halted`=0, `last_we`=0, `last_waddr`=0, `last_wdata`=0, all immediately (asynchronous). Combinational outputs follow the inputs with state RUN. Release is synchronous to the next edge.

## Test plan
- ALU write: sig=0x1, RDdst=8, AluOut=0x1234 → `reg_we`=1, addr 8, data 0x1234. Next cycle `last_*` = (1, 8, 0x1234) and `retired`=1.
- Loads with `read_data_in`=0x80FF7F01:
  - LB lane 3 → 0xFFFFFF80.
  - LBU lane 1 → 0x7F.
  - LH half 1 → 0xFFFF80FF.
  - LHU half 0 → 0x7F01.
  - LW → 0x80FF7F01.
- Link and $0:
  - JAL with sig=0x5, PC=0x00400010 → addr 31, data 0x00400014.
  - sig=0x1 with RDdst=0 → `reg_we`=0, and `retired` still increments.
- Halt/resume:
  - halt_in with a write → write occurs. Next cycle `halted`=1, and a further write request yields `reg_we`=0 with the counter unchanged.
  - resume → RUN, and writes resume.
- Bubbles and wrap:
  - IR=0 for 5 cycles → `retired` unchanged.
  - With CNT_W=4, 16 retirements → 0.
- Misalign and reset:
  - LW at AluOut=0x2 → `misalign`=1, sticky across later clean loads.
  - Assert reset mid-HALTED → all registered outputs 0 without a clock edge.
